uart_rx_msg_calc: RTL and testbench
===================================

Name: uart_rx_msg_calc

Overview:
UART receive path for the calculator frame; the inbound counterpart of the transmitter that slices messages into 8-bit ASCII fragments. It deserialises 8N1 characters from rxd_pin and reassembles them into an M-bit message buffer. A message completes on a terminator character or when the buffer is full. It drives status LEDs and hands complete messages to the calculator core.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud).
N, 8, bits per character.
M, 128, message buffer width in bits; capacity M/N = 16 characters.
TERM, 8'h0D, terminator character (CR); never stored.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
rxd_pin  input  1  UART serial input; idle high; asynchronous to clk.
byte_data  output  N  last correctly framed character.
byte_valid  output  1  one-cycle pulse when byte_data updates.
msg_data  output  M  completed message; last character in [N-1:0].
msg_len  output  5  number of characters in msg_data (1..16).
msg_valid  output  1  one-cycle pulse when msg_data/msg_len update.
frame_err  output  1  one-cycle pulse on a bad stop bit.
led  output  4  status: [0] receiver busy; [1] toggles per message; [2] sticky framing error; [3] buffer non-empty.

Behaviour:
- Reset (reset=0, async): FSM to IDLE. Bit/clock counters, byte_data, msg_data, msg_len, internal buffer and char count cleared. byte_valid, msg_valid, frame_err, led all 0. Both sync flops set to 1. Mid-frame reset abandons the partial character and partial message.
- rxd_pin passes through a 2-flop synchroniser (rx_s) before use. Edge-to-detect latency is 2 cycles.
- FSM states:
  IDLE: counters 0. rx_s==0 -> START.
  START: count to CLKS_PER_BIT/2-1 (mid start bit). At mid-bit, rx_s==0 -> DATA with bit index 0. rx_s==1 -> IDLE (glitch rejected, no pulse).
  DATA: every CLKS_PER_BIT cycles, sample rx_s into bit[index], LSB first. After bit 7 -> STOP.
  STOP: after CLKS_PER_BIT cycles, sample mid stop bit.
   - rx_s==1: byte_data latched and byte_valid pulsed for one cycle.
   - rx_s==0: frame_err pulsed, led[2] set, character discarded.
   Either way -> IDLE on the next cycle. A start bit directly after the stop bit is accepted (back-to-back frames).
- led[0]=1 whenever the state is not IDLE.
- Message assembler acts on the byte_valid cycle. msg_valid asserts the following cycle.
  - byte==TERM with count>0: copy buffer to msg_data, msg_len=count, pulse msg_valid, clear count/buffer.
  - byte==TERM with count==0: ignored, no pulse.
  - Any other byte: buffer = {buffer[M-N-1:0], byte}, count+1. If count reaches M/N, complete immediately (msg_len=16, msg_valid pulse, clear). A following TERM is then an empty-message no-op.
- msg_data/msg_len hold until the next msg_valid. They are not cleared by new incoming bytes.
- Unused upper bytes of msg_data are 0 for messages shorter than 16 characters.
- led[1] toggles on each msg_valid. led[3] = (count != 0).
- The receiver never stalls; there is no back-pressure. The consumer must capture msg_data before the next completion.

Test Plan:
(Benches use CLKS_PER_BIT=16, so the bit period is 160 ns at 100 MHz.)
1. Send 'a'(0x61) then 0x0D. -> byte_valid twice, byte_data 0x61 then 0x0D. msg_valid once with msg_len=1, msg_data=128'h61, led[1]=1, led[3] back to 0.
2. Send "12+3" then CR back-to-back, no idle gap. -> msg_len=4, msg_data[31:0]=32'h31322B33, upper bits 0. No frame_err.
3. Send 0x55 with stop bit forced 0. -> frame_err pulses once, no byte_valid, led[2]=1 until reset. The next good byte 0x41 + CR yields msg_len=1, msg_data=0x41.
4. Pull rxd_pin low for 4 cycles only, then high. -> returns to IDLE, no byte_valid, no frame_err. A following 0x30 is received correctly.
5. Send 16 chars 'A'..'P' then CR. -> msg_valid on the 16th char with msg_len=16, msg_data=128'h4142...50. The CR produces no second msg_valid.
6. Assert reset low mid-DATA of the 3rd character of "abc". -> all outputs 0 immediately, count 0. Then "xy"+CR yields msg_len=2, msg_data=16'h7879.

Source files
------------

// File: rtl/uart_rx_msg_calc.sv
// uart_rx_msg_calc
//   UART receive path for the calculator frame. It deserialises 8N1 characters
//   from rxd_pin and collects them into an M-bit message buffer. A message
//   completes when the terminator character arrives or when the buffer fills.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   rxd_pin    : UART serial input (idle high), asynchronous to clk
//   byte_data  : last correctly framed character
//   byte_valid : one-cycle pulse when byte_data updates
//   msg_data   : completed message, last character in [N-1:0]
//   msg_len    : number of characters in msg_data (1..M/N)
//   msg_valid  : one-cycle pulse when msg_data/msg_len update
//   frame_err  : one-cycle pulse on a bad stop bit
//   led        : [0] busy, [1] toggles per message, [2] sticky framing error,
//                [3] buffer non-empty
module uart_rx_msg_calc #(
  parameter int             CLKS_PER_BIT = 10417,
  parameter int             N            = 8,
  parameter int             M            = 128,
  parameter logic [N-1:0]   TERM         = 8'h0D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rxd_pin,
  output logic [N-1:0] byte_data,
  output logic         byte_valid,
  output logic [M-1:0] msg_data,
  output logic [4:0]   msg_len,
  output logic         msg_valid,
  output logic         frame_err,
  output logic [3:0]   led
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int CAP = M / N;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [4:0]    CAP_LAST  = 5'(CAP - 1);
  localparam logic [4:0]    CAP_LEN   = 5'(CAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-flop synchroniser; both flops reset to the idle line level so a reset
  // never looks like a start bit.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd_pin;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM with registered outputs.
  state_t          state_q;
  logic [CW-1:0]   clk_cnt_q;
  logic [IW-1:0]   bit_idx_q;
  logic [N-1:0]    shift_q;
  logic [N-1:0]    byte_data_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic            ferr_sticky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      ferr_sticky_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit gives IDLE half a bit of margin, so a
          // start bit immediately following the stop bit is still caught.
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (rx_s_q) begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q   <= 1'b1;
              ferr_sticky_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Message assembler, driven by the registered byte_valid pulse.
  logic [M-1:0] buf_q, buf_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [M-1:0] msg_data_q, msg_data_d;
  logic [4:0]   msg_len_q, msg_len_d;
  logic         msg_valid_q, msg_valid_d;
  logic         led1_q, led1_d;
  logic [M-1:0] shifted;

  assign shifted = {buf_q[M-N-1:0], byte_data_q};

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    msg_data_d  = msg_data_q;
    msg_len_d   = msg_len_q;
    msg_valid_d = 1'b0;
    led1_d      = led1_q;
    if (byte_valid_q) begin
      if (byte_data_q == TERM) begin
        // A terminator on an empty buffer (including right after a
        // full-buffer completion) is a no-op.
        if (cnt_q != 5'd0) begin
          msg_data_d  = buf_q;
          msg_len_d   = cnt_q;
          msg_valid_d = 1'b1;
          led1_d      = ~led1_q;
          buf_d       = '0;
          cnt_d       = '0;
        end
      end else if (cnt_q == CAP_LAST) begin
        msg_data_d  = shifted;
        msg_len_d   = CAP_LEN;
        msg_valid_d = 1'b1;
        led1_d      = ~led1_q;
        buf_d       = '0;
        cnt_d       = '0;
      end else begin
        buf_d = shifted;
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      msg_data_q  <= '0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      led1_q      <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      msg_data_q  <= msg_data_d;
      msg_len_q   <= msg_len_d;
      msg_valid_q <= msg_valid_d;
      led1_q      <= led1_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign msg_data   = msg_data_q;
  assign msg_len    = msg_len_q;
  assign msg_valid  = msg_valid_q;
  assign led        = {(cnt_q != 5'd0), ferr_sticky_q, led1_q, (state_q != IDLE)};

endmodule

// File: tb/tb_uart_rx_msg_calc.sv
module tb_uart_rx_msg_calc;

  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         rxd_pin;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic [127:0] msg_data;
  logic [4:0]   msg_len;
  logic         msg_valid;
  logic         frame_err;
  logic [3:0]   led;

  uart_rx_msg_calc #(
    .CLKS_PER_BIT(CPB),
    .N(8),
    .M(128),
    .TERM(8'h0D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd_pin(rxd_pin),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .msg_data(msg_data),
    .msg_len(msg_len),
    .msg_valid(msg_valid),
    .frame_err(frame_err),
    .led(led)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse monitor, sampled on the falling edge.
  int           bv_cnt = 0;
  int           mv_cnt = 0;
  int           fe_cnt = 0;
  logic [7:0]   byte_log [0:255];
  logic [127:0] last_msg = '0;
  logic [4:0]   last_len = '0;

  always @(negedge clk) begin
    if (byte_valid) begin
      byte_log[bv_cnt[7:0]] <= byte_data;
      bv_cnt <= bv_cnt + 1;
    end
    if (msg_valid) begin
      mv_cnt   <= mv_cnt + 1;
      last_msg <= msg_data;
      last_len <= msg_len;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic idle(input int n);
    rxd_pin = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rxd_pin = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_pin = d[i];
      repeat (CPB) @(posedge clk);
    end
    rxd_pin = stop_bit;
    repeat (CPB) @(posedge clk);
    rxd_pin = 1'b1;
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    rxd_pin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL rst_byte_data got=%h want=00", byte_data); end
    checks++; if (msg_data !== 128'h0) begin errors++; $display("FAIL rst_msg_data got=%h want=0", msg_data); end
    checks++; if (msg_len !== 5'd0) begin errors++; $display("FAIL rst_msg_len got=%0d want=0", msg_len); end
    checks++; if ({byte_valid, msg_valid, frame_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b want=000", {byte_valid, msg_valid, frame_err}); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL rst_led got=%b want=0000", led); end
    reset = 1'b1;
    idle(10);
  endtask

  task automatic test_single_char;
    int b0, m0;
    b0 = bv_cnt; m0 = mv_cnt;
    send_byte(8'h61, 1'b1);
    send_byte(8'h0D, 1'b1);
    idle(20);
    checks++; if (bv_cnt - b0 !== 2) begin errors++; $display("FAIL t1_byte_count got=%0d want=2", bv_cnt - b0); end
    checks++; if (byte_log[b0[7:0]] !== 8'h61) begin errors++; $display("FAIL t1_byte0 got=%h want=61", byte_log[b0[7:0]]); end
    checks++; if (byte_log[8'(b0 + 1)] !== 8'h0D) begin errors++; $display("FAIL t1_byte1 got=%h want=0d", byte_log[8'(b0 + 1)]); end
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t1_msg_count got=%0d want=1", mv_cnt - m0); end
    checks++; if (last_len !== 5'd1) begin errors++; $display("FAIL t1_len got=%0d want=1", last_len); end
    checks++; if (last_msg !== 128'h61) begin errors++; $display("FAIL t1_msg got=%h want=61", last_msg); end
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL t1_led1 got=%b want=1", led[1]); end
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL t1_led3 got=%b want=0", led[3]); end
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL t1_led0 got=%b want=0", led[0]); end
  endtask

  task automatic test_back_to_back;
    int m0, f0;
    logic [7:0] s [0:4];
    s[0] = 8'h31; s[1] = 8'h32; s[2] = 8'h2B; s[3] = 8'h33; s[4] = 8'h0D;
    m0 = mv_cnt; f0 = fe_cnt;
    for (int i = 0; i < 5; i++) send_byte(s[i], 1'b1);
    idle(20);
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t2_msg_count got=%0d want=1", mv_cnt - m0); end
    checks++; if (last_len !== 5'd4) begin errors++; $display("FAIL t2_len got=%0d want=4", last_len); end
    checks++; if (last_msg !== 128'h31322B33) begin errors++; $display("FAIL t2_msg got=%h want=31322b33", last_msg); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL t2_frame_err got=%0d want=0", fe_cnt - f0); end
    checks++; if (led[1] !== 1'b0) begin errors++; $display("FAIL t2_led1 got=%b want=0", led[1]); end
  endtask

  task automatic test_frame_error;
    int b0, m0, f0;
    b0 = bv_cnt; m0 = mv_cnt; f0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    idle(40);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL t3_frame_err got=%0d want=1", fe_cnt - f0); end
    checks++; if (bv_cnt - b0 !== 0) begin errors++; $display("FAIL t3_no_byte got=%0d want=0", bv_cnt - b0); end
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL t3_led2 got=%b want=1", led[2]); end
    send_byte(8'h41, 1'b1);
    send_byte(8'h0D, 1'b1);
    idle(20);
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t3_msg_count got=%0d want=1", mv_cnt - m0); end
    checks++; if (last_len !== 5'd1) begin errors++; $display("FAIL t3_len got=%0d want=1", last_len); end
    checks++; if (last_msg !== 128'h41) begin errors++; $display("FAIL t3_msg got=%h want=41", last_msg); end
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL t3_led2_sticky got=%b want=1", led[2]); end
  endtask

  task automatic test_glitch;
    int b0, f0, m0;
    b0 = bv_cnt; f0 = fe_cnt; m0 = mv_cnt;
    rxd_pin = 1'b0;
    repeat (4) @(posedge clk);
    idle(40);
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL t4_idle got=%b want=0", led[0]); end
    checks++; if (bv_cnt - b0 !== 0) begin errors++; $display("FAIL t4_no_byte got=%0d want=0", bv_cnt - b0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL t4_no_ferr got=%0d want=0", fe_cnt - f0); end
    send_byte(8'h30, 1'b1);
    idle(10);
    checks++; if (byte_log[b0[7:0]] !== 8'h30) begin errors++; $display("FAIL t4_byte got=%h want=30", byte_log[b0[7:0]]); end
    checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL t4_led3 got=%b want=1", led[3]); end
    send_byte(8'h0D, 1'b1);
    idle(20);
    checks++; if (mv_cnt - m0 !== 1 || last_msg !== 128'h30) begin errors++; $display("FAIL t4_msg got=%h want=30", last_msg); end
  endtask

  task automatic test_full_buffer;
    int b0, m0;
    b0 = bv_cnt; m0 = mv_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h41 + i), 1'b1);
    idle(20);
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t5_msg_count got=%0d want=1", mv_cnt - m0); end
    checks++; if (last_len !== 5'd16) begin errors++; $display("FAIL t5_len got=%0d want=16", last_len); end
    checks++; if (last_msg !== 128'h4142434445464748494A4B4C4D4E4F50) begin errors++; $display("FAIL t5_msg got=%h want=4142434445464748494a4b4c4d4e4f50", last_msg); end
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL t5_led3 got=%b want=0", led[3]); end
    send_byte(8'h0D, 1'b1);
    idle(20);
    checks++; if (bv_cnt - b0 !== 17) begin errors++; $display("FAIL t5_byte_count got=%0d want=17", bv_cnt - b0); end
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t5_cr_noop got=%0d want=1", mv_cnt - m0); end
    checks++; if (msg_data !== 128'h4142434445464748494A4B4C4D4E4F50) begin errors++; $display("FAIL t5_hold got=%h", msg_data); end
  endtask

  task automatic test_mid_reset;
    int m0;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    idle(4);
    checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL t6_led3_pre got=%b want=1", led[3]); end
    // Start of 'c' (0x63): start bit, then bits 0..2 = 1,1,0.
    rxd_pin = 1'b0; repeat (CPB) @(posedge clk);
    rxd_pin = 1'b1; repeat (2 * CPB) @(posedge clk);
    rxd_pin = 1'b0; repeat (CPB / 2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL t6_led got=%b want=0000", led); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL t6_byte_data got=%h want=00", byte_data); end
    checks++; if (msg_data !== 128'h0 || msg_len !== 5'd0) begin errors++; $display("FAIL t6_msg got=%h len=%0d want=0", msg_data, msg_len); end
    rxd_pin = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b1;
    idle(10);
    m0 = mv_cnt;
    send_byte(8'h78, 1'b1);
    send_byte(8'h79, 1'b1);
    send_byte(8'h0D, 1'b1);
    idle(20);
    checks++; if (mv_cnt - m0 !== 1) begin errors++; $display("FAIL t6_msg_count got=%0d want=1", mv_cnt - m0); end
    checks++; if (last_len !== 5'd2) begin errors++; $display("FAIL t6_len got=%0d want=2", last_len); end
    checks++; if (last_msg !== 128'h7879) begin errors++; $display("FAIL t6_msg_data got=%h want=7879", last_msg); end
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL t6_led1 got=%b want=1", led[1]); end
  endtask

  initial begin
    test_reset;
    test_single_char;
    test_back_to_back;
    test_frame_error;
    test_glitch;
    test_full_buffer;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
